// File: rtl/bus_arbiter_4_if.sv
// bus_arbiter_4_if: request/grant and mux-control bundle between the bus masters and bus_arbiter_4
//   enable        arbiter enable; no new grants while 0
//   req[3:0]      request vector, held high while master i wants the bus
//   gnt[3:0]      registered one-hot grant
//   mux_sel[1:0]  owner index for the shared 4:1 mux Sel input
//   mux_enable    high only while a grant is active; drives the mux Enable input
//   busy          arbiter is not idle
//   timeout_pulse one-cycle pulse on a forced release (0 when the timeout feature is absent)
interface bus_arbiter_4_if;
   logic       enable;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] mux_sel;
   logic       mux_enable;
   logic       busy;
   logic       timeout_pulse;
   modport master (
      output enable, req,
      input  gnt, mux_sel, mux_enable, busy, timeout_pulse
   );
   modport slave (
      input  enable, req,
      output gnt, mux_sel, mux_enable, busy, timeout_pulse
   );
endinterface

// File: rtl/bus_arbiter_4.sv
// bus_arbiter_4: round-robin arbiter sharing one 4:1 bus mux among 4 masters
//   clk       system clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   bus       bus_arbiter_4_if.slave: enable, req in; gnt, mux_sel, mux_enable, busy, timeout_pulse out
//   max_hold  consecutive grant cycles before a forced release (2..65535), used only with ARB_TIMEOUT_EN
// Optional feature: define ARB_TIMEOUT_EN to force an owner off the bus after max_hold cycles
// when another master is waiting; without it the owner keeps the bus indefinitely.
module bus_arbiter_4 #(
   parameter int unsigned max_hold = 16
) (
   input logic            clk,
   input logic            rst,
   bus_arbiter_4_if.slave bus
);
   typedef enum logic [1:0] {st_idle, st_grant, st_gap} state_t;
   state_t     state, state_n;
   logic [3:0] gnt_n;
   logic [1:0] sel_n;
   logic [1:0] rr_ptr, ptr_n;
   logic [3:0] rot;
   logic [1:0] off;
   logic [1:0] win;
   logic       win_ok;
   logic       arb;
   logic       rel;
   logic       forced;
   if (max_hold < 2 || max_hold > 65535) begin : g_bad_max_hold
      $error("bus_arbiter_4: max_hold out of range");
   end
   // Rotate requests so bit 0 is the master at rr_ptr; the lowest set bit is then the winner.
   assign rot    = 4'({bus.req, bus.req} >> rr_ptr);
   assign off    = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
   assign win    = rr_ptr + off;
   assign win_ok = |rot;
`ifdef ARB_TIMEOUT_EN
   logic [15:0] hold_cnt, cnt_n;
   logic        at_max;
   logic        tp_n;
   assign at_max = hold_cnt == 16'(max_hold - 1);
   // Forced release only when someone else is actually waiting for the bus.
   assign forced = (state == st_grant) && at_max && |(bus.req & ~bus.gnt);
`else
   assign forced = 1'b0;
   assign bus.timeout_pulse = 1'b0;
`endif
   assign arb = (state != st_grant) && bus.enable && win_ok;
   assign rel = (state == st_grant) && (!bus.req[bus.mux_sel] || forced);
   always_comb begin
      state_n = arb ? st_grant : rel ? st_gap : (state == st_grant) ? st_grant : st_idle;
      gnt_n   = arb ? 4'b0001 << win : (state == st_grant && !rel) ? bus.gnt : 4'b0000;
      sel_n   = arb ? win : bus.mux_sel;
      ptr_n   = rel ? bus.mux_sel + 2'd1 : rr_ptr;
`ifdef ARB_TIMEOUT_EN
      cnt_n   = arb ? 16'd0 : (state == st_grant && !at_max) ? hold_cnt + 16'd1 : hold_cnt;
      tp_n    = forced;
`endif
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= st_idle;
         bus.gnt     <= 4'b0000;
         bus.mux_sel <= 2'd0;
         rr_ptr      <= 2'd0;
`ifdef ARB_TIMEOUT_EN
         hold_cnt          <= 16'd0;
         bus.timeout_pulse <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         bus.gnt     <= gnt_n;
         bus.mux_sel <= sel_n;
         rr_ptr      <= ptr_n;
`ifdef ARB_TIMEOUT_EN
         hold_cnt          <= cnt_n;
         bus.timeout_pulse <= tp_n;
`endif
      end
   end
   assign bus.mux_enable = |bus.gnt;
   assign bus.busy       = state != st_idle;
endmodule
